snn_psum_neuron_acc: RTL and testbench

- Clocked, parametrised successor to the CSP four-input partial-sum adder/threshold stage.
- Collects one partial sum per timestep from each of NUM_IN channels over valid/ready handshakes and adds them to a stored membrane potential.
- Compares the result against a runtime threshold and emits {spike, residual potential}.
- Sits between the PE partial-sum outputs and the output-spike packetiser in the SNN NoC datapath.

---
 rtl/snn_pkg.sv | 28 ++
 rtl/snn_psum_neuron_acc_if.sv | 33 +++
 rtl/snn_psum_tree.sv | 38 +++
 rtl/snn_psum_neuron_acc.sv | 119 +++++++++++
 tb/tb_snn_psum_neuron_acc.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/snn_pkg.sv
// +----------------------------------------------------------------------------+
// | Module : snn_pkg                                                           |
// | Desc   : Shared types and helpers for the SNN partial-sum neuron stage.    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package snn_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        COMPUTE = 2'd1,
        SEND    = 2'd2
    } state_t;

    // Width that holds base + NUM_IN psums without overflow.
    function automatic int sum_width(input int pot_w, input int num_in);
        return pot_w + $clog2(num_in) + 1;
    endfunction

    // Spike flag sits directly above the potential field in out_data.
    function automatic int spike_bit(input int pot_w);
        return pot_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/snn_psum_neuron_acc_if.sv
// +----------------------------------------------------------------------------+
// | Module : snn_psum_neuron_acc_if                                            |
// | Desc   : Partial-sum input and spike/potential output handshake bundle.    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface snn_psum_neuron_acc_if #(
    parameter int NUM_IN = 4,
    parameter int WIDTH  = 8,
    parameter int POT_W  = 12
);
    logic [NUM_IN-1:0]       psum_valid;
    logic [NUM_IN*WIDTH-1:0] psum_data;
    logic [NUM_IN-1:0]       psum_ready;
    logic [POT_W-1:0]        vth;
    logic                    pot_clear;
    logic                    out_valid;
    logic                    out_ready;
    logic [POT_W:0]          out_data;

    modport master (
        output psum_valid, psum_data, vth, pot_clear, out_ready,
        input  psum_ready, out_valid, out_data
    );

    modport slave (
        input  psum_valid, psum_data, vth, pot_clear, out_ready,
        output psum_ready, out_valid, out_data
    );
endinterface

`default_nettype wire

// File: rtl/snn_psum_tree.sv
// +----------------------------------------------------------------------------+
// | Module : snn_psum_tree                                                     |
// | Desc   : Combinational base + NUM_IN unsigned psum adder, saturated.       |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module snn_psum_tree
    import snn_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int WIDTH  = 8,
    parameter int POT_W  = 12
) (
    input  wire logic [POT_W-1:0]        base,
    input  wire logic [NUM_IN*WIDTH-1:0] psums,
    output logic      [POT_W-1:0]        sum
);
    localparam int SUM_W = sum_width(POT_W, NUM_IN);

    logic [SUM_W-1:0] w_terms [NUM_IN];
    logic [SUM_W-1:0] w_total;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_term
        assign w_terms[i] = SUM_W'(psums[i*WIDTH +: WIDTH]);
    end

    always_comb begin
        w_total = SUM_W'(base);
        for (int i = 0; i < NUM_IN; i++) begin
            w_total = w_total + w_terms[i];
        end
        sum = (|w_total[SUM_W-1:POT_W]) ? '1 : w_total[POT_W-1:0];
    end

endmodule

`default_nettype wire

// File: rtl/snn_psum_neuron_acc.sv
// +----------------------------------------------------------------------------+
// | Module : snn_psum_neuron_acc                                               |
// | Desc   : Collects NUM_IN psums per timestep, integrates, thresholds, emits |
// |          {spike, residual}. Optional leak via SNN_PSUM_LEAK_EN.            |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module snn_psum_neuron_acc
    import snn_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int WIDTH  = 8,
    parameter int POT_W  = 12,
    parameter int LEAK   = 1
) (
    input wire logic             clk,
    input wire logic             rst,
    snn_psum_neuron_acc_if.slave bus
);
    localparam int SPIKE_BIT = spike_bit(POT_W);

`ifdef SNN_PSUM_LEAK_EN
    localparam bit LEAK_ON = 1'b1;
`else
    localparam bit LEAK_ON = 1'b0;
`endif
    localparam logic [POT_W-1:0] LEAK_AMT = LEAK_ON ? POT_W'(LEAK) : '0;

    state_t                  r_state;
    logic [NUM_IN-1:0]       r_got;
    logic [NUM_IN*WIDTH-1:0] r_cap;
    logic [POT_W-1:0]        r_pot;
    logic                    r_clr_pend;
    logic                    r_out_valid;
    logic [POT_W:0]          r_out_data;

    logic [NUM_IN-1:0] w_take;
    logic [NUM_IN-1:0] w_got_next;
    logic              w_clr;
    logic [POT_W-1:0]  w_base;
    logic [POT_W-1:0]  w_acc;
    logic              w_spike;
    logic [POT_W-1:0]  w_newpot;

    assign bus.psum_ready = (!rst && r_state == COLLECT) ? ~r_got : '0;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;

    assign w_take     = bus.psum_valid & bus.psum_ready;
    assign w_got_next = r_got | w_take;

    // A clear arriving in the COMPUTE cycle itself still applies to it.
    assign w_clr  = r_clr_pend | bus.pot_clear;
    assign w_base = w_clr ? '0 : ((r_pot > LEAK_AMT) ? (r_pot - LEAK_AMT) : '0);

    snn_psum_tree #(
        .NUM_IN (NUM_IN),
        .WIDTH  (WIDTH),
        .POT_W  (POT_W)
    ) u_tree (
        .base  (w_base),
        .psums (r_cap),
        .sum   (w_acc)
    );

    assign w_spike  = (w_acc >= bus.vth);
    assign w_newpot = w_spike ? (w_acc - bus.vth) : w_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= COLLECT;
            r_got       <= '0;
            r_cap       <= '0;
            r_pot       <= '0;
            r_clr_pend  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (bus.pot_clear) begin
                r_clr_pend <= 1'b1;
            end
            case (r_state)
                COLLECT: begin
                    for (int i = 0; i < NUM_IN; i++) begin
                        if (w_take[i]) begin
                            r_cap[i*WIDTH +: WIDTH] <= bus.psum_data[i*WIDTH +: WIDTH];
                        end
                    end
                    r_got <= w_got_next;
                    if (&w_got_next) begin
                        r_state <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    r_pot                   <= w_newpot;
                    r_out_data[SPIKE_BIT]   <= w_spike;
                    r_out_data[POT_W-1:0]   <= w_newpot;
                    r_out_valid             <= 1'b1;
                    r_clr_pend              <= 1'b0;
                    r_got                   <= '0;
                    r_state                 <= SEND;
                end
                SEND: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= COLLECT;
                    end
                end
                default: begin
                    r_state <= COLLECT;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_snn_psum_neuron_acc.sv
// +----------------------------------------------------------------------------+
// | Module : tb_snn_psum_neuron_acc                                            |
// | Desc   : Directed self-checking bench for snn_psum_neuron_acc (no leak).   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_snn_psum_neuron_acc;
    localparam int NUM_IN = 4;
    localparam int WIDTH  = 8;
    localparam int POT_W  = 12;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    snn_psum_neuron_acc_if #(.NUM_IN(NUM_IN), .WIDTH(WIDTH), .POT_W(POT_W)) bus ();

    snn_psum_neuron_acc #(
        .NUM_IN (NUM_IN),
        .WIDTH  (WIDTH),
        .POT_W  (POT_W),
        .LEAK   (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // All four channels valid for one cycle; returns with the DUT in COMPUTE.
    task automatic drive_all(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d);
        bus.psum_data  = {d, c, b, a};
        bus.psum_valid = 4'hF;
        step();
        bus.psum_valid = 4'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.out_data !== 13'd0) begin bad++; $display("FAIL rst_data: got %h want 000", bus.out_data); end
        total++; if (bus.psum_ready !== 4'h0) begin bad++; $display("FAIL rst_ready: got %b want 0000", bus.psum_ready); end
        rst = 1'b0;
        #1;
        total++; if (bus.psum_ready !== 4'hF) begin bad++; $display("FAIL rst_rel_ready: got %b want 1111", bus.psum_ready); end
        step();
    endtask

    task automatic test_basic();
        drive_all(8'd10, 8'd20, 8'd5, 8'd15);
        total++; if (bus.out_valid !== 1'b0 || bus.psum_ready !== 4'h0) begin bad++; $display("FAIL basic_compute: valid %b ready %b want 0 0000", bus.out_valid, bus.psum_ready); end
        step();
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 13'd50) begin bad++; $display("FAIL basic_ts1: valid %b data %h want 1 032", bus.out_valid, bus.out_data); end
        step();
        total++; if (bus.out_valid !== 1'b0 || bus.psum_ready !== 4'hF) begin bad++; $display("FAIL basic_back: valid %b ready %b want 0 1111", bus.out_valid, bus.psum_ready); end
        drive_all(8'd5, 8'd5, 8'd2, 8'd3);
        step();
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 13'h1001) begin bad++; $display("FAIL basic_ts2: valid %b data %h want 1 1001", bus.out_valid, bus.out_data); end
        step();
    endtask

    task automatic test_stagger();
        bus.psum_data  = {8'd0, 8'd7, 8'd0, 8'd0};
        bus.psum_valid = 4'b0100;
        step();
        total++; if (bus.psum_ready !== 4'b1011) begin bad++; $display("FAIL stag_ch2: ready %b want 1011", bus.psum_ready); end
        bus.psum_data  = {8'd4, 8'd99, 8'd3, 8'd0};
        bus.psum_valid = 4'b1110;
        step();
        total++; if (bus.psum_ready !== 4'b0001) begin bad++; $display("FAIL stag_ch13: ready %b want 0001", bus.psum_ready); end
        for (int k = 0; k < 5; k++) begin
            step();
            total++; if (bus.psum_ready !== 4'b0001 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL stag_hold%0d: ready %b valid %b want 0001 0", k, bus.psum_ready, bus.out_valid); end
        end
        bus.psum_data  = {8'd4, 8'd99, 8'd3, 8'd6};
        bus.psum_valid = 4'hF;
        step();
        bus.psum_valid = 4'h0;
        step();
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 13'd21) begin bad++; $display("FAIL stag_sum: valid %b data %h want 1 015", bus.out_valid, bus.out_data); end
        step();
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        drive_all(8'd1, 8'd2, 8'd3, 8'd4);
        step();
        for (int k = 0; k < 4; k++) begin
            total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 13'd31 || bus.psum_ready !== 4'h0) begin bad++; $display("FAIL bp_hold%0d: valid %b data %h ready %b want 1 01f 0000", k, bus.out_valid, bus.out_data, bus.psum_ready); end
            step();
        end
        bus.out_ready = 1'b1;
        step();
        total++; if (bus.out_valid !== 1'b0 || bus.psum_ready !== 4'hF) begin bad++; $display("FAIL bp_release: valid %b ready %b want 0 1111", bus.out_valid, bus.psum_ready); end
    endtask

    task automatic test_pot_clear();
        bus.out_ready = 1'b0;
        drive_all(8'd10, 8'd5, 8'd2, 8'd2);
        step();
        total++; if (bus.out_data !== 13'd50) begin bad++; $display("FAIL clr_pre: data %h want 032", bus.out_data); end
        bus.pot_clear = 1'b1;
        step();
        bus.pot_clear = 1'b0;
        bus.out_ready = 1'b1;
        step();
        drive_all(8'd1, 8'd1, 8'd1, 8'd1);
        step();
        total++; if (bus.out_data !== 13'd4) begin bad++; $display("FAIL clr_send: data %h want 004", bus.out_data); end
        step();
        drive_all(8'd2, 8'd2, 8'd2, 8'd2);
        bus.pot_clear = 1'b1;
        step();
        bus.pot_clear = 1'b0;
        total++; if (bus.out_data !== 13'd8) begin bad++; $display("FAIL clr_compute: data %h want 008", bus.out_data); end
        step();
    endtask

    task automatic test_saturation();
        logic [12:0] exp_arr [4] = '{13'd1028, 13'd2048, 13'd3068, 13'd4088};
        bus.vth = 12'd4095;
        for (int k = 0; k < 4; k++) begin
            drive_all(8'd255, 8'd255, 8'd255, 8'd255);
            step();
            total++; if (bus.out_data !== exp_arr[k]) begin bad++; $display("FAIL sat_fill%0d: data %h want %h", k, bus.out_data, exp_arr[k]); end
            step();
        end
        drive_all(8'd255, 8'd255, 8'd255, 8'd255);
        step();
        total++; if (bus.out_data !== 13'h1000) begin bad++; $display("FAIL sat_clamp: data %h want 1000", bus.out_data); end
        step();
        bus.vth = 12'd0;
        drive_all(8'd1, 8'd2, 8'd3, 8'd4);
        step();
        total++; if (bus.out_data !== 13'h100A) begin bad++; $display("FAIL vth0_a: data %h want 100a", bus.out_data); end
        step();
        drive_all(8'd0, 8'd0, 8'd0, 8'd0);
        step();
        total++; if (bus.out_data !== 13'h100A) begin bad++; $display("FAIL vth0_b: data %h want 100a", bus.out_data); end
        step();
    endtask

    task automatic test_reset_mid();
        bus.vth        = 12'd64;
        bus.psum_data  = {8'd0, 8'd0, 8'd9, 8'd9};
        bus.psum_valid = 4'b0011;
        step();
        total++; if (bus.psum_ready !== 4'b1100) begin bad++; $display("FAIL rmid_part: ready %b want 1100", bus.psum_ready); end
        bus.psum_valid = 4'h0;
        rst = 1'b1;
        step();
        total++; if (bus.psum_ready !== 4'h0 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL rmid_in_rst: ready %b valid %b want 0000 0", bus.psum_ready, bus.out_valid); end
        step();
        rst = 1'b0;
        #1;
        total++; if (bus.psum_ready !== 4'hF) begin bad++; $display("FAIL rmid_ready: ready %b want 1111", bus.psum_ready); end
        for (int k = 0; k < 3; k++) begin
            step();
            total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rmid_noout%0d: valid %b want 0", k, bus.out_valid); end
        end
        drive_all(8'd1, 8'd1, 8'd1, 8'd1);
        step();
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 13'd4) begin bad++; $display("FAIL rmid_after: valid %b data %h want 1 004", bus.out_valid, bus.out_data); end
        step();
    endtask

    initial begin
        rst            = 1'b1;
        bus.psum_valid = '0;
        bus.psum_data  = '0;
        bus.vth        = 12'd64;
        bus.pot_clear  = 1'b0;
        bus.out_ready  = 1'b1;
        test_reset();
        test_basic();
        test_stagger();
        test_backpressure();
        test_pot_clear();
        test_saturation();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t limit 200000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
